nco_phase_accumulator: RTL and testbench

NCO_PHASE_ACCUMULATOR -- requirements
Module: nco_phase_accumulator

---
 rtl/nco_pkg.sv | 5 +
 rtl/nco_ftw_shadow.sv | 44 ++++
 rtl/nco_phase_accumulator.sv | 69 ++++++
 tb/tb_nco_phase_accumulator.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// nco_pkg: constants shared by the NCO phase chain
package nco_pkg;
    localparam int PHASE_W = 32;
    localparam int QUANT_W = 4;
endpackage

// File: rtl/nco_ftw_shadow.sv
// nco_ftw_shadow: single-entry tuning-word shadow with valid/ready capture and enable-timed promotion
module nco_ftw_shadow
    import nco_pkg::*;
#(
    parameter int W = PHASE_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] ftw_in,
    input  logic         ftw_valid,
    input  logic         en,
    output logic         ftw_ready,
    output logic [W-1:0] ftw_active
);
    logic         pending_q, pending_d;
    logic [W-1:0] shadow_q, shadow_d;
    logic [W-1:0] active_q, active_d;
    logic         accept, promote;

    assign ftw_ready  = !pending_q;
    assign ftw_active = active_q;

    // accept only while empty; promote to active on the first enabled edge, which still increments with the old word
    always_comb begin
        accept    = !pending_q && ftw_valid;
        promote   = pending_q && en;
        pending_d = accept || (pending_q && !en);
        shadow_d  = accept ? ftw_in : shadow_q;
        active_d  = promote ? shadow_q : active_q;
    end

    // handshake state; reset drops any word still waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            shadow_q  <= '0;
            active_q  <= '0;
        end else begin
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
        end
    end
endmodule

// File: rtl/nco_phase_accumulator.sv
// nco_phase_accumulator: phase accumulator with handshaked tuning word, phase offset and registered phase/wrap output
module nco_phase_accumulator #(
    parameter int PHASE_W = nco_pkg::PHASE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [PHASE_W-1:0] ftw_in,
    input  logic               ftw_valid,
    output logic               ftw_ready,
    input  logic [PHASE_W-1:0] pow_in,
    input  logic               pow_load,
    input  logic               phase_clr,
    output logic [PHASE_W-1:0] phase_out,
    output logic               phase_valid,
    output logic               wrap
);
    logic [PHASE_W-1:0] ftw_active;
    logic [PHASE_W:0]   sum;
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic               carry_q, carry_d;
    logic [PHASE_W-1:0] pow_q, pow_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               wrap_q, en_q, valid_q;

    nco_ftw_shadow #(.W(PHASE_W)) u_shadow (
        .clk        (clk),
        .rst_n      (rst_n),
        .ftw_in     (ftw_in),
        .ftw_valid  (ftw_valid),
        .en         (en),
        .ftw_ready  (ftw_ready),
        .ftw_active (ftw_active)
    );

    assign phase_out   = phase_q;
    assign phase_valid = valid_q;
    assign wrap        = wrap_q;

    // clear beats enable and kills the carry; carry is only raised by a real increment
    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, ftw_active};
        acc_d   = phase_clr ? '0 : (en ? sum[PHASE_W-1:0] : acc_q);
        carry_d = !phase_clr && en && sum[PHASE_W];
        pow_d   = pow_load ? pow_in : pow_q;
        phase_d = acc_q + pow_q;
    end

    // accumulator stage then output stage; en is delayed twice to stay aligned with phase_out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
            pow_q   <= '0;
            phase_q <= '0;
            wrap_q  <= 1'b0;
            en_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
            pow_q   <= pow_d;
            phase_q <= phase_d;
            wrap_q  <= carry_q;
            en_q    <= en;
            valid_q <= en_q;
        end
    end
endmodule

// File: tb/tb_nco_phase_accumulator.sv
// tb_nco_phase_accumulator: scoreboard bench for the NCO phase accumulator
module tb_nco_phase_accumulator;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [W-1:0] ftw_in = '0;
    logic         ftw_valid = 1'b0;
    logic         ftw_ready;
    logic [W-1:0] pow_in = '0;
    logic         pow_load = 1'b0;
    logic         phase_clr = 1'b0;
    logic [W-1:0] phase_out;
    logic         phase_valid;
    logic         wrap;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [W-1:0] ph;
        logic         w;
    } exp_t;
    exp_t sb[$];

    logic [W-1:0] m_acc, m_act, m_sh, m_pow;
    logic         m_pend;

    nco_phase_accumulator #(.PHASE_W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .ftw_in      (ftw_in),
        .ftw_valid   (ftw_valid),
        .ftw_ready   (ftw_ready),
        .pow_in      (pow_in),
        .pow_load    (pow_load),
        .phase_clr   (phase_clr),
        .phase_out   (phase_out),
        .phase_valid (phase_valid),
        .wrap        (wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        m_acc = '0; m_act = '0; m_sh = '0; m_pow = '0; m_pend = 1'b0;
        sb.delete();
    endtask

    task automatic idle_inputs();
        en = 1'b0; ftw_valid = 1'b0; pow_load = 1'b0; phase_clr = 1'b0;
        ftw_in = '0; pow_in = '0;
    endtask

    // one clock: predict, push expected sample, then check ready and pop any valid sample
    task automatic tick();
        logic [W:0] s;
        exp_t e, g;
        s = {1'b0, m_acc} + {1'b0, m_act};
        if (phase_clr) m_acc = '0;
        else if (en) m_acc = s[W-1:0];
        if (pow_load) m_pow = pow_in;
        if (en) begin
            e.ph = m_acc + m_pow;
            e.w  = !phase_clr && s[W];
            sb.push_back(e);
        end
        if (m_pend && en) begin
            m_act = m_sh; m_pend = 1'b0;
        end else if (!m_pend && ftw_valid) begin
            m_sh = ftw_in; m_pend = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ftw_ready !== !m_pend) begin
            errors++;
            $display("FAIL ftw_ready: got %b expected %b", ftw_ready, !m_pend);
        end
        if (phase_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: got phase_valid=1 expected no sample");
            end else begin
                g = sb.pop_front();
                if (phase_out !== g.ph || wrap !== g.w) begin
                    errors++;
                    $display("FAIL sample: got phase=%h wrap=%b expected phase=%h wrap=%b",
                             phase_out, wrap, g.ph, g.w);
                end
            end
        end else begin
            checks++;
            if (wrap !== 1'b0) begin
                errors++;
                $display("FAIL wrap_idle: got %b expected 0", wrap);
            end
        end
    endtask

    task automatic drain();
        idle_inputs();
        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d leftover samples expected 0", sb.size());
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_ftw(input logic [W-1:0] v);
        en = 1'b0; ftw_in = v; ftw_valid = 1'b1;
        tick();
        ftw_valid = 1'b0;
    endtask

    task automatic test_reset();
        model_clear();
        @(negedge clk);
        checks++;
        if (phase_out !== '0 || wrap !== 1'b0 || phase_valid !== 1'b0 || ftw_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got phase=%h wrap=%b valid=%b ready=%b expected 0 0 0 1",
                     phase_out, wrap, phase_valid, ftw_ready);
        end
        rst_n = 1'b1;
        en = 1'b1;
        repeat (4) begin
            tick();
            checks++;
            if (phase_out !== '0) begin
                errors++;
                $display("FAIL reset_no_ftw: got %h expected 0", phase_out);
            end
        end
        drain();
    endtask

    task automatic test_ramp();
        int n = 0;
        do_reset();
        load_ftw(32'h1000_0000);
        en = 1'b1;
        repeat (36) begin
            tick();
            if (phase_valid === 1'b1) begin
                checks++;
                if (phase_out[31:28] !== 4'(n % 16) || wrap !== (n % 16 == 0 && n > 0)) begin
                    errors++;
                    $display("FAIL ramp[%0d]: got top=%h wrap=%b expected top=%h wrap=%b",
                             n, phase_out[31:28], wrap, 4'(n % 16), (n % 16 == 0 && n > 0));
                end
                n++;
            end
        end
        checks++;
        if (n != 35) begin
            errors++;
            $display("FAIL ramp_count: got %0d samples expected 35", n);
        end
        drain();
    endtask

    task automatic test_pow();
        logic [W-1:0] prev;
        do_reset();
        load_ftw(32'h1000_0000);
        en = 1'b1;
        repeat (6) tick();
        prev = phase_out;
        pow_in = 32'h8000_0000;
        pow_load = 1'b1;
        tick();
        pow_load = 1'b0;
        checks++;
        if (phase_out !== prev + 32'h1000_0000) begin
            errors++;
            $display("FAIL pow_load_edge: got %h expected %h", phase_out, prev + 32'h1000_0000);
        end
        tick();
        checks++;
        if (phase_out !== prev + 32'hA000_0000) begin
            errors++;
            $display("FAIL pow_applied: got %h expected %h", phase_out, prev + 32'hA000_0000);
        end
        repeat (3) tick();
        drain();
    endtask

    task automatic test_handshake();
        logic [W-1:0] hold;
        do_reset();
        load_ftw(32'h1000_0000);
        en = 1'b1;
        repeat (4) tick();
        en = 1'b0;
        ftw_in = 32'h3000_0000;
        ftw_valid = 1'b1;
        tick();
        ftw_in = 32'h5000_0000;
        tick();
        ftw_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (ftw_ready !== 1'b0) begin
            errors++;
            $display("FAIL hs_held: got ready=%b expected 0", ftw_ready);
        end
        hold = phase_out;
        en = 1'b1;
        tick();
        checks++;
        if (ftw_ready !== 1'b1) begin
            errors++;
            $display("FAIL hs_ready_back: got ready=%b expected 1", ftw_ready);
        end
        tick();
        checks++;
        if (phase_out !== hold + 32'h1000_0000) begin
            errors++;
            $display("FAIL hs_old_ftw: got %h expected %h", phase_out, hold + 32'h1000_0000);
        end
        tick();
        checks++;
        if (phase_out !== hold + 32'h4000_0000) begin
            errors++;
            $display("FAIL hs_new_ftw: got %h expected %h", phase_out, hold + 32'h4000_0000);
        end
        tick();
        checks++;
        if (phase_out !== hold + 32'h7000_0000) begin
            errors++;
            $display("FAIL hs_new_ftw2: got %h expected %h", phase_out, hold + 32'h7000_0000);
        end
        drain();
    endtask

    task automatic test_clear();
        do_reset();
        load_ftw(32'h1000_0000);
        en = 1'b1;
        repeat (16) tick();
        phase_clr = 1'b1;
        tick();
        phase_clr = 1'b0;
        checks++;
        if (phase_out !== 32'hF000_0000) begin
            errors++;
            $display("FAIL clr_setup: got %h expected f0000000", phase_out);
        end
        tick();
        checks++;
        if (phase_out !== '0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL clr_zero: got phase=%h wrap=%b expected 0 0", phase_out, wrap);
        end
        tick();
        checks++;
        if (phase_out !== 32'h1000_0000) begin
            errors++;
            $display("FAIL clr_restart: got %h expected 10000000", phase_out);
        end
        drain();
    endtask

    task automatic test_async_reset();
        do_reset();
        load_ftw(32'h1000_0000);
        en = 1'b1;
        repeat (5) tick();
        load_ftw(32'h3000_0000);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (phase_out !== '0 || wrap !== 1'b0 || phase_valid !== 1'b0 || ftw_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got phase=%h wrap=%b valid=%b ready=%b expected 0 0 0 1",
                     phase_out, wrap, phase_valid, ftw_ready);
        end
        idle_inputs();
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        repeat (5) begin
            tick();
            checks++;
            if (phase_out !== '0) begin
                errors++;
                $display("FAIL post_reset_hold: got %h expected 0", phase_out);
            end
        end
        drain();
    endtask

    task automatic test_wrap_all();
        int n = 0;
        do_reset();
        load_ftw(32'hFFFF_FFFF);
        en = 1'b1;
        repeat (10) begin
            tick();
            if (phase_valid === 1'b1) begin
                checks++;
                if (phase_out !== 32'(0 - n) || wrap !== (n >= 2)) begin
                    errors++;
                    $display("FAIL decrement[%0d]: got phase=%h wrap=%b expected phase=%h wrap=%b",
                             n, phase_out, wrap, 32'(0 - n), (n >= 2));
                end
                n++;
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_pow();
        test_handshake();
        test_clear();
        test_async_reset();
        test_wrap_all();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
